// File: rtl/div_arbiter.sv
// div_arbiter: round-robin arbiter sharing one external divider between two requesters.
// Latency: a request seen in IDLE is granted on that edge; done_o follows div_ready_i by one edge.
// Backpressure: stall_o holds each requester off until its division completes or is annulled.
// Ports: req/signed/op1/op2/annul per requester in, done_o/stall_o/result_o back to them;
//        div_start/annul/signed/op1/op2 out to the divider, div_ready_i/div_result_i back.
module div_arbiter #(
  parameter int unsigned RELEASE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_i,
  input  logic        req1_i,
  input  logic        signed0_i,
  input  logic        signed1_i,
  input  logic [31:0] op1_0_i,
  input  logic [31:0] op2_0_i,
  input  logic [31:0] op1_1_i,
  input  logic [31:0] op2_1_i,
  input  logic        annul0_i,
  input  logic        annul1_i,
  output logic [1:0]  done_o,
  output logic [1:0]  stall_o,
  output logic [63:0] result_o,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        div_signed_o,
  output logic [31:0] div_op1_o,
  output logic [31:0] div_op2_o,
  input  logic        div_ready_i,
  input  logic [63:0] div_result_i
);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RELEASE} state_t;

  // A zero release length skips RELEASE entirely; the counter still needs one bit.
  localparam int unsigned REL_N = (RELEASE_CYCLES == 0) ? 1 : RELEASE_CYCLES;
  localparam int unsigned CW    = (REL_N > 1) ? $clog2(REL_N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REL_N - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;     // requester served most recently
  logic          gnt_q, gnt_d;       // requester owning the current operation
  logic          start_q, start_d;
  logic          annul_q, annul_d;
  logic          signed_q, signed_d;
  logic [31:0]   op1_q, op1_d;
  logic [31:0]   op2_q, op2_d;
  logic [63:0]   result_q, result_d;
  logic [1:0]    done_q, done_d;

  logic elig0, elig1, pick1, g_req, g_annul;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    start_d  = start_q;
    annul_d  = 1'b0;
    signed_d = signed_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    result_d = result_q;
    done_d   = 2'b00;

    elig0 = req0_i & ~annul0_i;
    elig1 = req1_i & ~annul1_i;
    // On a tie the requester not served last wins.
    pick1 = elig1 & ~(elig0 & last_q);

    g_req   = gnt_q ? req1_i   : req0_i;
    g_annul = gnt_q ? annul1_i : annul0_i;

    case (state_q)
      ST_IDLE: begin
        if (elig0 | elig1) begin
          gnt_d    = pick1;
          last_d   = pick1;
          signed_d = pick1 ? signed1_i : signed0_i;
          op1_d    = pick1 ? op1_1_i   : op1_0_i;
          op2_d    = pick1 ? op2_1_i   : op2_0_i;
          start_d  = 1'b1;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Cancellation is checked first so it beats a same-cycle completion.
        if (g_annul | ~g_req) begin
          annul_d = 1'b1;
          start_d = 1'b0;
          cnt_d   = '0;
          if (RELEASE_CYCLES == 0) state_d = ST_IDLE;
          else                     state_d = ST_RELEASE;
        end else if (div_ready_i) begin
          result_d = div_result_i;
          done_d   = gnt_q ? 2'b10 : 2'b01;
          start_d  = 1'b0;
          cnt_d    = '0;
          if (RELEASE_CYCLES == 0) state_d = ST_IDLE;
          else                     state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        start_d = 1'b0;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      gnt_q    <= 1'b0;
      start_q  <= 1'b0;
      annul_q  <= 1'b0;
      signed_q <= 1'b0;
      op1_q    <= '0;
      op2_q    <= '0;
      result_q <= '0;
      done_q   <= 2'b00;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      start_q  <= start_d;
      annul_q  <= annul_d;
      signed_q <= signed_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign done_o       = done_q;
  assign result_o     = result_q;
  assign div_start_o  = start_q;
  assign div_annul_o  = annul_q;
  assign div_signed_o = signed_q;
  assign div_op1_o    = op1_q;
  assign div_op2_o    = op2_q;
  // Pending but ungranted requesters stall too; the done cycle releases the stall.
  assign stall_o = {req1_i & ~annul1_i & ~done_q[1], req0_i & ~annul0_i & ~done_q[0]};

endmodule

// File: tb/tb_div_arbiter.sv
module tb_div_arbiter;
  localparam int R = 2;

  logic        clk = 1'b0, rst = 1'b0;
  logic        req0_i = 1'b0, req1_i = 1'b0, signed0_i = 1'b0, signed1_i = 1'b0;
  logic        annul0_i = 1'b0, annul1_i = 1'b0;
  logic [31:0] op1_0_i = '0, op2_0_i = '0, op1_1_i = '0, op2_1_i = '0;
  logic [1:0]  done_o, stall_o;
  logic [63:0] result_o;
  logic        div_start_o, div_annul_o, div_signed_o;
  logic [31:0] div_op1_o, div_op2_o;
  logic        div_ready_i;
  logic [63:0] div_result_i;

  int total = 0, bad = 0;
  int dcnt = 0;

  always #5 clk = ~clk;

  div_arbiter #(.RELEASE_CYCLES(R)) dut (
    .clk(clk), .rst(rst),
    .req0_i(req0_i), .req1_i(req1_i), .signed0_i(signed0_i), .signed1_i(signed1_i),
    .op1_0_i(op1_0_i), .op2_0_i(op2_0_i), .op1_1_i(op1_1_i), .op2_1_i(op2_1_i),
    .annul0_i(annul0_i), .annul1_i(annul1_i),
    .done_o(done_o), .stall_o(stall_o), .result_o(result_o),
    .div_start_o(div_start_o), .div_annul_o(div_annul_o), .div_signed_o(div_signed_o),
    .div_op1_o(div_op1_o), .div_op2_o(div_op2_o),
    .div_ready_i(div_ready_i), .div_result_i(div_result_i)
  );

  // Reference quotient/remainder from plain arithmetic; zero divisor gives zero.
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = a; sb = b; q = sa / sb; r = sa % sb;
      return {r, q};
    end
    return {a % b, a / b};
  endfunction

  // Divider stand-in: ready 35 cycles into a start (3 for a zero divisor).
  always @(posedge clk) dcnt <= div_start_o ? dcnt + 1 : 0;
  assign div_ready_i  = div_start_o && (dcnt == ((div_op2_o == 32'd0) ? 3 : 35));
  assign div_result_i = ref_div(div_signed_o, div_op1_o, div_op2_o);

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    repeat (R + 2) tick();
  endtask

  task automatic drive_req(input int k, input logic v, input logic s, input logic [31:0] a, input logic [31:0] b);
    if (k == 0) begin req0_i = v; signed0_i = s; op1_0_i = a; op2_0_i = b; end
    else        begin req1_i = v; signed1_i = s; op1_1_i = a; op2_1_i = b; end
  endtask

  task automatic new_op(output logic s, output logic [31:0] a, output logic [31:0] b, input logic allow_zero);
    s = 1'($urandom_range(0, 1));
    a = $urandom;
    if (allow_zero && $urandom_range(0, 4) == 0) b = 32'd0;
    else if ($urandom_range(0, 1) == 1) b = $urandom_range(1, 100);
    else b = $urandom;
    if (b == 32'd0 && !allow_zero) b = 32'd3;
    if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
  endtask

  task automatic wait_start(input int budget, output int n);
    n = 0;
    while (n < budget) begin
      tick(); n++;
      if (div_start_o) return;
    end
    n = -1;
  endtask

  // Counts edges until a done pulse; optionally scrambles requester operands meanwhile.
  task automatic wait_done(input int budget, input logic [1:0] scr, output int n,
                           output logic [1:0] d, output logic stable);
    logic [64:0] snap;
    snap = {div_signed_o, div_op1_o, div_op2_o};
    n = 0; d = 2'b00; stable = 1'b1;
    while (n < budget) begin
      if (scr[0]) begin op1_0_i = $urandom; op2_0_i = $urandom; signed0_i = 1'($urandom_range(0, 1)); end
      if (scr[1]) begin op1_1_i = $urandom; op2_1_i = $urandom; signed1_i = 1'($urandom_range(0, 1)); end
      tick(); n++;
      if ({div_signed_o, div_op1_o, div_op2_o} !== snap) stable = 1'b0;
      if (done_o !== 2'b00) begin d = done_o; return; end
    end
    n = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    total++; if (done_o !== 2'b00) begin bad++; $display("FAIL reset_done: got %b want 00", done_o); end
    total++; if (result_o !== 64'd0) begin bad++; $display("FAIL reset_result: got %h want 0", result_o); end
    total++; if ({div_start_o, div_annul_o, div_signed_o} !== 3'b000) begin
      bad++; $display("FAIL reset_ctrl: got %b want 000", {div_start_o, div_annul_o, div_signed_o}); end
    total++; if ({div_op1_o, div_op2_o} !== 64'd0) begin
      bad++; $display("FAIL reset_ops: got %h want 0", {div_op1_o, div_op2_o}); end
    req0_i = 1'b1; #1;
    total++; if (stall_o !== 2'b01) begin bad++; $display("FAIL reset_stall: got %b want 01", stall_o); end
    req0_i = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_unsigned();
    int n; logic [1:0] d; logic st;
    drive_req(0, 1'b1, 1'b0, 32'd100, 32'd7);
    wait_start(5, n);
    total++; if (n !== 1) begin bad++; $display("FAIL uns_grant: got %0d edges want 1", n); end
    total++; if ({div_signed_o, div_op1_o, div_op2_o} !== {1'b0, 32'd100, 32'd7}) begin
      bad++; $display("FAIL uns_ops: got %b %h %h want 0 64 7", div_signed_o, div_op1_o, div_op2_o); end
    total++; if (stall_o !== 2'b01) begin bad++; $display("FAIL uns_stall: got %b want 01", stall_o); end
    wait_done(80, 2'b01, n, d, st);
    total++; if (n !== 36) begin bad++; $display("FAIL uns_latency: got %0d want 36", n); end
    total++; if (d !== 2'b01) begin bad++; $display("FAIL uns_done: got %b want 01", d); end
    total++; if (result_o !== 64'h00000002_0000000E) begin
      bad++; $display("FAIL uns_result: got %h want 000000020000000e", result_o); end
    total++; if (st !== 1'b1) begin bad++; $display("FAIL uns_stable: got %b want 1", st); end
    total++; if (stall_o !== 2'b00) begin bad++; $display("FAIL uns_stall_done: got %b want 00", stall_o); end
    req0_i = 1'b0;
    tick();
    total++; if (done_o !== 2'b00) begin bad++; $display("FAIL uns_pulse: got %b want 00", done_o); end
    settle();
  endtask

  task automatic test_zero_div();
    int n; logic [1:0] d; logic st; logic [31:0] a;
    a = $urandom;
    drive_req(0, 1'b1, 1'($urandom_range(0, 1)), a, 32'd0);
    wait_start(5, n);
    wait_done(80, 2'b00, n, d, st);
    total++; if (n !== 4) begin bad++; $display("FAIL zero_latency: got %0d want 4", n); end
    total++; if (d !== 2'b01) begin bad++; $display("FAIL zero_done: got %b want 01", d); end
    total++; if (result_o !== 64'd0) begin bad++; $display("FAIL zero_result: got %h want 0", result_o); end
    req0_i = 1'b0;
    settle();
  endtask

  task automatic test_signed();
    int n; logic [1:0] d; logic st;
    drive_req(1, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_start(5, n);
    total++; if (div_signed_o !== 1'b1) begin bad++; $display("FAIL sgn_flag: got %b want 1", div_signed_o); end
    wait_done(80, 2'b10, n, d, st);
    total++; if (n !== 36) begin bad++; $display("FAIL sgn_latency: got %0d want 36", n); end
    total++; if (d !== 2'b10) begin bad++; $display("FAIL sgn_done: got %b want 10", d); end
    total++; if (result_o !== 64'hFFFFFFFF_FFFFFFFD) begin
      bad++; $display("FAIL sgn_result: got %h want fffffffffffffffd", result_o); end
    req1_i = 1'b0;
    settle();
  endtask

  task automatic test_annul();
    int n; logic [1:0] d; logic st; logic [63:0] prev;
    logic s0, s1; logic [31:0] a0, b0, a1, b1;
    new_op(s0, a0, b0, 1'b0);
    new_op(s1, a1, b1, 1'b0);
    prev = result_o;
    drive_req(0, 1'b1, s0, a0, b0);
    wait_start(5, n);
    drive_req(1, 1'b1, s1, a1, b1);
    repeat (9) tick();
    annul0_i = 1'b1; #1;
    total++; if (stall_o !== 2'b10) begin bad++; $display("FAIL ann_stall: got %b want 10", stall_o); end
    tick();
    total++; if (div_annul_o !== 1'b1) begin bad++; $display("FAIL ann_pulse: got %b want 1", div_annul_o); end
    total++; if (done_o !== 2'b00) begin bad++; $display("FAIL ann_nodone: got %b want 00", done_o); end
    total++; if (div_start_o !== 1'b0) begin bad++; $display("FAIL ann_start: got %b want 0", div_start_o); end
    total++; if (result_o !== prev) begin bad++; $display("FAIL ann_result: got %h want %h", result_o, prev); end
    req0_i = 1'b0; annul0_i = 1'b0;
    tick();
    total++; if (div_annul_o !== 1'b0) begin bad++; $display("FAIL ann_width: got %b want 0", div_annul_o); end
    wait_start(20, n);
    total++; if (n !== R) begin bad++; $display("FAIL ann_regrant: got %0d want %0d", n, R); end
    total++; if ({div_signed_o, div_op1_o, div_op2_o} !== {s1, a1, b1}) begin
      bad++; $display("FAIL ann_ops1: got %b %h %h want %b %h %h", div_signed_o, div_op1_o, div_op2_o, s1, a1, b1); end
    wait_done(80, 2'b00, n, d, st);
    total++; if (n !== 36 || d !== 2'b10) begin bad++; $display("FAIL ann_done1: got %0d/%b want 36/10", n, d); end
    total++; if (result_o !== ref_div(s1, a1, b1)) begin
      bad++; $display("FAIL ann_result1: got %h want %h", result_o, ref_div(s1, a1, b1)); end
    req1_i = 1'b0;
    settle();
  endtask

  task automatic test_annul_vs_done();
    int n; logic [63:0] prev; logic s; logic [31:0] a, b;
    new_op(s, a, b, 1'b0);
    prev = result_o;
    drive_req(0, 1'b1, s, a, b);
    wait_start(5, n);
    repeat (35) tick();
    annul0_i = 1'b1;
    tick();
    total++; if (done_o !== 2'b00) begin bad++; $display("FAIL race_nodone: got %b want 00", done_o); end
    total++; if (div_annul_o !== 1'b1) begin bad++; $display("FAIL race_annul: got %b want 1", div_annul_o); end
    total++; if (result_o !== prev) begin bad++; $display("FAIL race_result: got %h want %h", result_o, prev); end
    req0_i = 1'b0; annul0_i = 1'b0;
    settle();
  endtask

  task automatic test_withdraw();
    int n; logic [63:0] prev; logic s; logic [31:0] a, b;
    new_op(s, a, b, 1'b0);
    prev = result_o;
    drive_req(1, 1'b1, s, a, b);
    wait_start(5, n);
    repeat ($urandom_range(2, 30)) tick();
    req1_i = 1'b0;
    tick();
    total++; if ({div_annul_o, done_o} !== 3'b100) begin
      bad++; $display("FAIL wd_annul: got annul=%b done=%b want 1/00", div_annul_o, done_o); end
    total++; if (result_o !== prev) begin bad++; $display("FAIL wd_result: got %h want %h", result_o, prev); end
    settle();
  endtask

  task automatic test_reset_mid_busy();
    int n; logic [1:0] d; logic st;
    logic s0, s1; logic [31:0] a0, b0, a1, b1;
    new_op(s0, a0, b0, 1'b0);
    new_op(s1, a1, b1, 1'b1);
    drive_req(0, 1'b1, s0, a0, b0);
    wait_start(5, n);
    repeat (15) tick();
    rst = 1'b1; #1;
    total++; if ({done_o, result_o, div_start_o, div_annul_o, div_signed_o, div_op1_o, div_op2_o} !== '0) begin
      bad++; $display("FAIL rstmid_zero: got done=%b res=%h start=%b op1=%h want all 0", done_o, result_o, div_start_o, div_op1_o); end
    drive_req(1, 1'b1, s1, a1, b1);
    tick(); tick(); tick();
    total++; if (done_o !== 2'b00) begin bad++; $display("FAIL rstmid_nodone: got %b want 00", done_o); end
    rst = 1'b0;
    wait_start(5, n);
    total++; if (n !== 1) begin bad++; $display("FAIL rstmid_grant: got %0d want 1", n); end
    total++; if ({div_signed_o, div_op1_o, div_op2_o} !== {s0, a0, b0}) begin
      bad++; $display("FAIL rstmid_tie: got op1=%h want %h", div_op1_o, a0); end
    wait_done(80, 2'b00, n, d, st);
    total++; if (n !== 36 || d !== 2'b01) begin bad++; $display("FAIL rstmid_done: got %0d/%b want 36/01", n, d); end
    total++; if (result_o !== ref_div(s0, a0, b0)) begin
      bad++; $display("FAIL rstmid_result: got %h want %h", result_o, ref_div(s0, a0, b0)); end
    req0_i = 1'b0;
    wait_start(20, n);
    wait_done(80, 2'b00, n, d, st);
    total++; if (d !== 2'b10 || result_o !== ref_div(s1, a1, b1)) begin
      bad++; $display("FAIL rstmid_second: got %b %h want 10 %h", d, result_o, ref_div(s1, a1, b1)); end
    req1_i = 1'b0;
    settle();
  endtask

  // Randomized rounds checked against a round-robin model of who should be served next.
  task automatic test_contention();
    logic pend [2];
    logic s [2];
    logic [31:0] a [2];
    logic [31:0] b [2];
    int last, w, n, gap, gap_exp, lat_exp;
    logic [1:0] d; logic st;
    rst = 1'b1; tick(); rst = 1'b0;
    last = 1;
    for (int k = 0; k < 2; k++) begin
      pend[k] = 1'b1;
      new_op(s[k], a[k], b[k], 1'b1);
      drive_req(k, 1'b1, s[k], a[k], b[k]);
    end
    gap_exp = 1;
    for (int round = 0; round < 14; round++) begin
      if (!pend[0] && !pend[1]) begin
        for (int k = 0; k < 2; k++) begin
          pend[k] = 1'($urandom_range(0, 1));
        end
        if (!pend[0] && !pend[1]) pend[$urandom_range(0, 1)] = 1'b1;
        for (int k = 0; k < 2; k++) begin
          if (pend[k]) begin
            new_op(s[k], a[k], b[k], 1'b1);
            drive_req(k, 1'b1, s[k], a[k], b[k]);
          end
        end
        gap_exp = 1;
      end
      w = (pend[0] && pend[1]) ? 1 - last : (pend[1] ? 1 : 0);
      last = w;
      lat_exp = (b[w] == 32'd0) ? 4 : 36;
      wait_start(50, gap);
      total++; if (gap !== gap_exp) begin bad++; $display("FAIL cont_gap r%0d: got %0d want %0d", round, gap, gap_exp); end
      total++; if ({div_signed_o, div_op1_o, div_op2_o} !== {s[w], a[w], b[w]}) begin
        bad++; $display("FAIL cont_ops r%0d: got op1=%h want %h (req%0d)", round, div_op1_o, a[w], w); end
      wait_done(80, 2'b00, n, d, st);
      total++; if (n !== lat_exp) begin bad++; $display("FAIL cont_latency r%0d: got %0d want %0d", round, n, lat_exp); end
      total++; if (d !== ((w == 1) ? 2'b10 : 2'b01)) begin bad++; $display("FAIL cont_done r%0d: got %b want req%0d", round, d, w); end
      total++; if (result_o !== ref_div(s[w], a[w], b[w])) begin
        bad++; $display("FAIL cont_result r%0d: got %h want %h", round, result_o, ref_div(s[w], a[w], b[w])); end
      total++; if (st !== 1'b1) begin bad++; $display("FAIL cont_stable r%0d: got %b want 1", round, st); end
      drive_req(w, 1'b0, s[w], a[w], b[w]);
      pend[w] = 1'b0;
      gap_exp = R + 1;
      if ($urandom_range(0, 1) == 1) begin
        tick();
        new_op(s[w], a[w], b[w], 1'b1);
        drive_req(w, 1'b1, s[w], a[w], b[w]);
        pend[w] = 1'b1;
        gap_exp = R;
      end
      if (!pend[0] && !pend[1]) settle();
    end
    req0_i = 1'b0; req1_i = 1'b0;
    settle();
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_zero_div();
    test_signed();
    test_annul();
    test_annul_vs_done();
    test_withdraw();
    test_reset_mid_busy();
    test_contention();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
